dmem_responder: RTL and testbench

//   Responder end of the cpu data-memory port: serves loads and stores issued by the core.

---
 rtl/dmem_responder.sv | 210 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the cpu: byte-lane RAM plus an MMIO page holding
// an LED register, a free-running cycle counter and an 8N1 UART transmitter.
module dmem_responder #(
  parameter int RAM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 868,
  parameter int LED_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      data_addr,
  output logic [31:0]      data_rd,
  input  logic [31:0]      data_wr,
  input  logic [3:0]       data_wr_en,
  output logic [LED_W-1:0] led,
  output logic             uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [31:0] LED_ADDR  = 32'h8000_0000;
  localparam logic [31:0] UART_ADDR = 32'h8000_0004;
  localparam logic [31:0] CYC_ADDR  = 32'h8000_0008;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  logic [31:0]      ram_q [RAM_WORDS];
  logic [31:0]      ram_word_d;
  logic [31:0]      ram_rd;
  logic             ram_we;
  logic             in_ram;
  logic [AW-1:0]    word_idx;
  logic [4:0]       byte_sh;
  logic [3:0]       lane_en;
  logic [31:0]      wdata_sh;
  logic [31:0]      rd_word;

  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      cycles_q, cycles_d;
  tx_state_e        state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       byte_q, byte_d;
  logic             tx_q, tx_d;
  logic             busy;
  logic             baud_done;
  logic             led_store;
  logic             tx_store;

  assign word_idx  = data_addr[AW+1:2];
  assign in_ram    = (data_addr[31:AW+2] == {(30-AW){1'b0}});
  assign byte_sh   = {data_addr[1:0], 3'b000};
  assign wdata_sh  = data_wr << byte_sh;
  assign ram_rd    = ram_q[word_idx];
  assign ram_we    = in_ram && (data_wr_en != 4'b0000);
  assign led_store = (data_addr == LED_ADDR) && data_wr_en[0];
  assign tx_store  = (data_addr == UART_ADDR) && data_wr_en[0];
  assign busy      = (state_q != ST_IDLE);
  assign baud_done = (baud_q == BAUD_LAST);
  assign led       = led_q;
  assign uart_tx   = tx_q;

  // Lane i lands on byte a+i; lanes shifted past byte 3 are dropped, never wrapped.
  always_comb begin
    lane_en = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      if (j >= int'(data_addr[1:0])) begin
        lane_en[j] = data_wr_en[j - int'(data_addr[1:0])];
      end else begin
        lane_en[j] = 1'b0;
      end
    end
  end

  // Merge the enabled store bytes into the currently stored word.
  always_comb begin
    ram_word_d = ram_rd;
    for (int j = 0; j < 4; j++) begin
      if (lane_en[j]) begin
        ram_word_d[8*j +: 8] = wdata_sh[8*j +: 8];
      end else begin
        ram_word_d[8*j +: 8] = ram_rd[8*j +: 8];
      end
    end
  end

  // RAM array write port; contents deliberately survive rst.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[word_idx] <= ram_word_d;
    end
  end

  // Zero-latency read mux; the addressed word is shifted down by the byte offset.
  always_comb begin
    rd_word = 32'h0000_0000;
    if (in_ram) begin
      rd_word = ram_rd;
    end else if (data_addr[31:2] == LED_ADDR[31:2]) begin
      rd_word = 32'(led_q);
    end else if (data_addr[31:2] == UART_ADDR[31:2]) begin
      rd_word = {31'b0, busy};
    end else if (data_addr[31:2] == CYC_ADDR[31:2]) begin
      rd_word = cycles_q;
    end else begin
      rd_word = 32'h0000_0000;
    end
    data_rd = rd_word >> byte_sh;
  end

  // Next-state for LED register and cycle counter.
  always_comb begin
    cycles_d = cycles_q + 32'd1;
    if (led_store) begin
      led_d = data_wr[LED_W-1:0];
    end else begin
      led_d = led_q;
    end
  end

  // UART transmit FSM: next state, counters and the line level for the next cycle.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (tx_store) begin
          byte_d  = data_wr[7:0];
          baud_d  = {BW{1'b0}};
          bit_d   = 3'd0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_d  = {BW{1'b0}};
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + {{(BW-1){1'b0}}, 1'b1};
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d = {BW{1'b0}};
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + {{(BW-1){1'b0}}, 1'b1};
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_d  = {BW{1'b0}};
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + {{(BW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        baud_d  = {BW{1'b0}};
        bit_d   = 3'd0;
        state_d = ST_IDLE;
      end
    endcase

    // Registering the line level from the next state keeps uart_tx glitch-free.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = byte_d[bit_d];
      ST_STOP:  tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // Control state registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q    <= {LED_W{1'b0}};
      cycles_q <= 32'h0000_0000;
      state_q  <= ST_IDLE;
      baud_q   <= {BW{1'b0}};
      bit_q    <= 3'd0;
      byte_q   <= 8'h00;
      tx_q     <= 1'b1;
    end else begin
      led_q    <= led_d;
      cycles_q <= cycles_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus queues expected values, a
// negedge monitor pops and compares them against the live DUT outputs.
module tb_dmem_responder;

  localparam logic [31:0] LED_A  = 32'h8000_0000;
  localparam logic [31:0] UART_A = 32'h8000_0004;
  localparam logic [31:0] CYC_A  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_addr;
  logic [31:0] data_rd;
  logic [31:0] data_wr;
  logic [3:0]  data_wr_en;
  logic [7:0]  led;
  logic        uart_tx;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  dmem_responder #(
    .RAM_WORDS   (16),
    .CLKS_PER_BIT(4),
    .LED_W       (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_addr (data_addr),
    .data_rd   (data_rd),
    .data_wr   (data_wr),
    .data_wr_en(data_wr_en),
    .led       (led),
    .uart_tx   (uart_tx)
  );

  always #5 clk = ~clk;

  // sel: 0 = data_rd, 1 = led, 2 = uart_tx
  task automatic expect_v(input string name, input int sel, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    data_addr  = a;
    data_wr_en = 4'b0000;
    expect_v(name, 0, exp);
    cyc();
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] en);
    data_addr  = a;
    data_wr    = d;
    data_wr_en = en;
    cyc();
    data_wr_en = 4'b0000;
  endtask

  // Monitor: compare every pending expectation against the outputs mid-cycle.
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      case (c.sel)
        0:       act = data_rd;
        1:       act = 32'(led);
        default: act = {31'b0, uart_tx};
      endcase
      n_checks++;
      if (act !== c.exp) begin
        n_errors++;
        $display("FAIL %s: got %08h expected %08h", c.name, act, c.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame;
    rst        = 1'b1;
    data_addr  = 32'h0;
    data_wr    = 32'h0;
    data_wr_en = 4'b0000;
    cyc();

    n_checks++;
    if (uart_tx !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_tx_direct: got %b expected 1", uart_tx);
    end

    // Reset state
    expect_v("rst_led", 1, 32'h0);
    expect_v("rst_tx", 2, 32'h1);
    rd("rst_busy", UART_A, 32'h0);
    rd("rst_cycles", CYC_A, 32'h0);
    rst = 1'b0;

    // Cycle counter counts edges since reset release
    for (int n = 0; n < 5; n++) begin
      rd("cycles_n", CYC_A, 32'(n));
    end

    // Word store and shifted read
    st(32'h8, 32'h1122_3344, 4'b1111);
    st(32'hC, 32'hCAFE_F00D, 4'b1111);
    rd("word_rd8", 32'h8, 32'h1122_3344);
    rd("word_rdA", 32'hA, 32'h0000_1122);

    // Byte store; same-cycle read must see old data
    data_addr  = 32'h9;
    data_wr    = 32'h0000_00AB;
    data_wr_en = 4'b0001;
    expect_v("rdw_old", 0, 32'h0011_2233);
    cyc();
    data_wr_en = 4'b0000;
    rd("byte_st", 32'h8, 32'h1122_AB44);

    // Half store at offset 3: upper lane dropped, next word untouched
    st(32'hB, 32'h0000_BEEF, 4'b0011);
    rd("half_st", 32'h8, 32'hEF22_AB44);
    rd("no_wrap", 32'hC, 32'hCAFE_F00D);

    // Just past the RAM top: reads 0, stores do not alias word 0
    st(32'h0, 32'h0102_0304, 4'b1111);
    rd("ram_end_rd", 32'h40, 32'h0);
    st(32'h40, 32'hFFFF_FFFF, 4'b1111);
    rd("ram_alias", 32'h0, 32'h0102_0304);

    // LED register and unmapped space
    st(LED_A, 32'h0000_01FF, 4'b0001);
    expect_v("led_val", 1, 32'hFF);
    rd("led_rd", LED_A, 32'h0000_00FF);
    st(LED_A, 32'h0000_0022, 4'b0010);
    rd("led_lane0_only", LED_A, 32'h0000_00FF);
    rd("unmapped_rd", 32'h9000_0000, 32'h0);
    st(32'h9000_0000, 32'hDEAD_BEEF, 4'b1111);
    expect_v("unmapped_led", 1, 32'hFF);
    rd("unmapped_ram", 32'h8, 32'hEF22_AB44);
    rd("mmio_hole", 32'h8000_000C, 32'h0);

    // UART frame for 0x5A, with a dropped store mid-frame
    data_addr  = UART_A;
    data_wr    = 32'h0000_005A;
    data_wr_en = 4'b0001;
    expect_v("busy_pre", 0, 32'h0);
    expect_v("tx_idle", 2, 32'h1);
    cyc();
    data_wr_en = 4'b0000;
    frame = {1'b1, 8'h5A, 1'b0};
    for (int k = 0; k < 40; k++) begin
      data_addr = UART_A;
      if (k == 10) begin
        data_wr    = 32'h0000_00FF;
        data_wr_en = 4'b0001;
      end else begin
        data_wr_en = 4'b0000;
      end
      expect_v("tx_bit", 2, {31'b0, frame[k/4]});
      expect_v("busy_frame", 0, 32'h1);
      cyc();
    end

    // Busy clears exactly after 40 clk; new byte accepted that cycle
    data_addr  = UART_A;
    data_wr    = 32'h0000_0033;
    data_wr_en = 4'b0001;
    expect_v("busy_done", 0, 32'h0);
    expect_v("tx_done", 2, 32'h1);
    cyc();
    data_wr_en = 4'b0000;
    frame = {1'b1, 8'h33, 1'b0};
    for (int k = 0; k < 15; k++) begin
      expect_v("tx2_bit", 2, {31'b0, frame[k/4]});
      expect_v("busy2", 0, 32'h1);
      cyc();
    end

    // Asynchronous reset mid-frame
    rst = 1'b1;
    #1;
    n_checks++;
    if (led !== 8'h00) begin
      n_errors++;
      $display("FAIL rst_mid_led_direct: got %02h expected 00", led);
    end
    expect_v("rst_mid_tx", 2, 32'h1);
    expect_v("rst_mid_led", 1, 32'h0);
    expect_v("rst_mid_busy", 0, 32'h0);
    cyc();
    rd("rst_mid_cycles", CYC_A, 32'h0);
    rst = 1'b0;
    rd("ram_keep8", 32'h8, 32'hEF22_AB44);
    rd("ram_keepC", 32'hC, 32'hCAFE_F00D);
    expect_v("tx_after_rst", 2, 32'h1);
    cyc();

    // Counter wrap
    force dut.cycles_q = 32'hFFFF_FFFF;
    data_addr = CYC_A;
    expect_v("cycles_max", 0, 32'hFFFF_FFFF);
    @(negedge clk);
    #1;
    release dut.cycles_q;
    cyc();
    expect_v("cycles_wrap", 0, 32'h0);
    cyc();
    cyc();

    if ((n_errors != 0) || (n_checks < 12)) begin
      $display("FAIL: %0d checks, %0d errors", n_checks, n_errors);
    end else begin
      $display("PASS: %0d checks, %0d errors", n_checks, n_errors);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
